csr_trap_unit: RTL and testbench
================================

Name: csr_trap_unit

Overview:
Parametrised machine-mode CSR block for the RV32 pipeline core. It holds the full M-mode trap CSR set with WARL masking, 64-bit mcycle/minstret counters and hardware trap entry/mret stacking of mstatus. It also produces the interrupt request, interrupt cause and trap vector. It sits beside the register file; the decode stage reads it and the WB stage writes it.

Parameters:
XLEN, 32, data width of CSR read/write ports (32 only in this generation; all masks assume 32).
MTVEC_RESET, 32'h0, reset value of mtvec (BASE and MODE).
HAS_COUNTERS, 1, 1 implements mcycle/minstret/h; 0 makes them read 0 and writes are ignored.
VECTORED_EN, 1, 1 allows mtvec.MODE=1 (vectored); 0 forces MODE to read 0.

Ports:
clk  in  1  core clock.
rst_n  in  1  asynchronous, active-low reset.
raddr  in  12  CSR read address.
rdata  out  XLEN  combinational read data, 0 when raddr is unimplemented.
rd_illegal  out  1  combinational, 1 when raddr is unimplemented.
waddr  in  12  CSR write address.
wdata  in  XLEN  write operand.
csr_w  in  1  write strobe.
csr_wsc_mode  in  2  01 write, 10 set, 11 clear, 00 treated as write.
retire  in  1  one instruction retired this cycle.
trap_valid  in  1  synchronous exception or interrupt taken this cycle.
trap_cause  in  XLEN  mcause value; bit31 is the interrupt flag.
trap_pc  in  XLEN  PC saved to mepc.
trap_val  in  XLEN  value saved to mtval.
mret  in  1  mret executes this cycle.
irq_ext, irq_timer, irq_sw  in  1 each  level interrupt lines.
irq_req  out  1  interrupt should be taken.
irq_cause  out  XLEN  cause for the highest-priority pending interrupt.
trap_vector  out  XLEN  target PC for the current trap_cause.
mepc_o  out  XLEN  mret target.
mstatus_o  out  XLEN  current mstatus.

Behaviour:
- Implemented CSRs: mstatus 300, mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, mtval 343, mip 344, mcycle B00, minstret B02, mcycleh B80, minstreth B82. Any other address sets rd_illegal; writes to it are ignored.
- Reset values: mstatus 32'h0000_1800 (MPP=11, MIE=0, MPIE=0); mie 0; mtvec MTVEC_RESET; counters 0; all others 0. Therefore irq_req=0 out of reset.
- WARL masks:
  - mstatus: only MIE[3] and MPIE[7] writable; MPP[12:11] reads 11; all other bits read 0.
  - mie: only bits 3, 7 and 11 writable.
  - mtvec: bit1 reads 0; bit0 reads 0 if VECTORED_EN=0.
  - mepc: bits[1:0] read 0.
  - mip: read-only; writes are ignored.
- Set/clear form the new value from the current register value, then apply the mask. Write latency is 1 cycle; a read of the same address in the same cycle returns the old value (no bypass).
- mip: MEIP[11], MTIP[7] and MSIP[3] are the irq_* inputs registered once, so 1 cycle of latency.
- irq_req = mstatus.MIE & |(mip & mie).
- irq_cause: bit31 set; code by priority MEI 11 > MSI 3 > MTI 7.
- Trap entry on trap_valid, applied at the clock edge:
  - mepc <= trap_pc & ~3; mcause <= trap_cause; mtval <= trap_val.
  - MPIE <= MIE; MIE <= 0.
- mret: MIE <= MPIE; MPIE <= 1.
- trap_vector = {mtvec[31:2],2'b00}, plus 4*trap_cause[3:0] when MODE=1 and trap_cause[31]=1.
- Same-cycle priority: trap_valid > mret > csr_w. A lower-priority update to a register touched by a higher one is dropped; csr_w to an unrelated CSR still commits.
- Counters:
  - mcycle increments every cycle; minstret increments when retire=1.
  - Each is 64 bits and wraps to 0 from all-ones.
  - A CSR write to either half replaces that half, and that counter skips its increment in that cycle.
  - The low-half carry propagates into the high half in the same cycle.
- rst_n assertion mid-operation clears all state immediately and asynchronously; pending trap/mret inputs are lost.

Decomposition:
- Shared package csr_pkg holds:
  - CSR address constants.
  - Per-CSR writable-bit masks.
  - mstatus bit positions (MIE, MPIE, MPP).
  - Interrupt code constants (3, 7, 11).
  - Write-mode encodings.
- One sub-module, csr_counter64: 64-bit counter with inc, lo_we and hi_we inputs and wrap rules. It is instantiated twice and removed by generate when HAS_COUNTERS=0.

Test Plan:
- Reset then read 300/304/305: expect 0x1800, 0, MTVEC_RESET. Read 0x7C0: expect rd_illegal=1, rdata=0.
- Write mstatus 0xFFFF_FFFF, then read: expect 0x1888. Clear 0x8: expect 0x1880. Write mie 0xFFFF_FFFF: reads 0x888. Write mtvec 0x1003 with VECTORED_EN=1: reads 0x1001.
- Set MIE=1, mie bit7=1, raise irq_timer: irq_req=1 exactly 1 cycle later with irq_cause 0x8000_0007. Raise irq_ext as well: cause becomes 0x8000_000B.
- trap_valid with cause 0x8000_000B, pc 0x202, mtvec 0x1001: trap_vector=0x102C same cycle; next cycle mepc=0x200, MIE=0, MPIE=1. Then mret: MIE=1, MPIE=1.
- Write mcycle=0xFFFF_FFFF: next increment gives mcycle=0, mcycleh=1. In a cycle with both retire=1 and a minstret write of 5, read 5 afterwards.
- trap_valid, mret and a csr_w to mscratch in the same cycle: trap effects apply, mret is ignored, mscratch is updated. Assert rst_n low mid-sequence: all CSRs return to reset values without a clock edge.

Source files
------------

// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared constants, masks and helpers for the M-mode CSR block
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [31:0] MSTATUS_RO    = 32'h0000_1800;
  localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;
  localparam logic [31:0] MEPC_WMASK    = 32'hFFFF_FFFC;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MSTATUS_MPP  = 11;

  localparam logic [4:0] IRQ_MSI = 5'd3;
  localparam logic [4:0] IRQ_MTI = 5'd7;
  localparam logic [4:0] IRQ_MEI = 5'd11;

  typedef enum logic [1:0] {
    WSC_NONE  = 2'b00,
    WSC_WRITE = 2'b01,
    WSC_SET   = 2'b10,
    WSC_CLEAR = 2'b11
  } wsc_mode_e;

  function automatic logic [31:0] wsc_apply(input logic [1:0] mode,
                                            input logic [31:0] cur,
                                            input logic [31:0] wd);
    case (mode)
      WSC_SET:   return cur | wd;
      WSC_CLEAR: return cur & ~wd;
      default:   return wd;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// rtl/csr_counter64.sv - 64-bit wrapping counter with per-half CSR writes
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        lo_we,
  input  logic        hi_we,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  // A write to either half suppresses that cycle's increment entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (lo_we || hi_we) begin
      if (lo_we) count[31:0]  <= wdata;
      if (hi_we) count[63:32] <= wdata;
    end else if (inc) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/csr_trap_unit.sv
// rtl/csr_trap_unit.sv - machine-mode trap CSRs, counters, interrupt and vector logic
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter int          XLEN         = 32,
  parameter logic [31:0] MTVEC_RESET  = 32'h0,
  parameter bit          HAS_COUNTERS = 1'b1,
  parameter bit          VECTORED_EN  = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [11:0]     raddr,
  output logic [XLEN-1:0] rdata,
  output logic            rd_illegal,
  input  logic [11:0]     waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            csr_w,
  input  logic [1:0]      csr_wsc_mode,
  input  logic            retire,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_val,
  input  logic            mret,
  input  logic            irq_ext,
  input  logic            irq_timer,
  input  logic            irq_sw,
  output logic            irq_req,
  output logic [XLEN-1:0] irq_cause,
  output logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] mepc_o,
  output logic [XLEN-1:0] mstatus_o
);

  localparam logic [31:0] MTVEC_WMASK = VECTORED_EN ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;

  logic [XLEN-1:0] mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, mip_q;
  logic [XLEN-1:0] mstatus_rd, wr_val, pend;
  logic [XLEN:0]   rd_word, wr_word;
  logic [63:0]     mcycle, minstret;
  logic            wr_ok;
  logic [4:0]      irq_code;

  assign mstatus_rd = mstatus_q | MSTATUS_RO;

  function automatic logic [XLEN:0] csr_read(input logic [11:0] addr);
    logic [XLEN:0] r;
    r = '0;
    case (addr)
      CSR_MSTATUS:   r[XLEN-1:0] = mstatus_rd;
      CSR_MIE:       r[XLEN-1:0] = mie_q;
      CSR_MTVEC:     r[XLEN-1:0] = mtvec_q;
      CSR_MSCRATCH:  r[XLEN-1:0] = mscratch_q;
      CSR_MEPC:      r[XLEN-1:0] = mepc_q;
      CSR_MCAUSE:    r[XLEN-1:0] = mcause_q;
      CSR_MTVAL:     r[XLEN-1:0] = mtval_q;
      CSR_MIP:       r[XLEN-1:0] = mip_q;
      CSR_MCYCLE:    r[XLEN-1:0] = mcycle[31:0];
      CSR_MCYCLEH:   r[XLEN-1:0] = mcycle[63:32];
      CSR_MINSTRET:  r[XLEN-1:0] = minstret[31:0];
      CSR_MINSTRETH: r[XLEN-1:0] = minstret[63:32];
      default:       r[XLEN]     = 1'b1;
    endcase
    return r;
  endfunction

  always_comb begin
    rd_word = csr_read(raddr);
    wr_word = csr_read(waddr);
  end

  assign rdata      = rd_word[XLEN-1:0];
  assign rd_illegal = rd_word[XLEN];
  // Set/clear operate on the architecturally visible value; the mask is applied per register.
  assign wr_val     = wsc_apply(csr_wsc_mode, wr_word[XLEN-1:0], wdata);
  assign wr_ok      = csr_w && !wr_word[XLEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_q  <= '0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RESET & MTVEC_WMASK;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mip_q      <= '0;
    end else begin
      mip_q <= {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_sw, 3'b0};
      if (trap_valid) begin
        mstatus_q[MSTATUS_MIE]  <= 1'b0;
        mstatus_q[MSTATUS_MPIE] <= mstatus_q[MSTATUS_MIE];
        mepc_q   <= trap_pc & MEPC_WMASK;
        mcause_q <= trap_cause;
        mtval_q  <= trap_val;
      end else if (mret) begin
        mstatus_q[MSTATUS_MIE]  <= mstatus_q[MSTATUS_MPIE];
        mstatus_q[MSTATUS_MPIE] <= 1'b1;
      end
      if (wr_ok) begin
        case (waddr)
          CSR_MSTATUS:  if (!trap_valid && !mret) mstatus_q <= wr_val & MSTATUS_WMASK;
          CSR_MIE:      mie_q      <= wr_val & MIE_WMASK;
          CSR_MTVEC:    mtvec_q    <= wr_val & MTVEC_WMASK;
          CSR_MSCRATCH: mscratch_q <= wr_val;
          CSR_MEPC:     if (!trap_valid) mepc_q   <= wr_val & MEPC_WMASK;
          CSR_MCAUSE:   if (!trap_valid) mcause_q <= wr_val;
          CSR_MTVAL:    if (!trap_valid) mtval_q  <= wr_val;
          default: ;
        endcase
      end
    end
  end

  generate
    if (HAS_COUNTERS) begin : g_cnt
      csr_counter64 u_mcycle (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (1'b1),
        .lo_we (wr_ok && waddr == CSR_MCYCLE),
        .hi_we (wr_ok && waddr == CSR_MCYCLEH),
        .wdata (wr_val[31:0]),
        .count (mcycle)
      );
      csr_counter64 u_minstret (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire),
        .lo_we (wr_ok && waddr == CSR_MINSTRET),
        .hi_we (wr_ok && waddr == CSR_MINSTRETH),
        .wdata (wr_val[31:0]),
        .count (minstret)
      );
    end else begin : g_no_cnt
      assign mcycle   = '0;
      assign minstret = '0;
    end
  endgenerate

  // Priority among pending sources: external, then software, then timer.
  assign pend = mip_q & mie_q;
  always_comb begin
    irq_code = 5'd0;
    if (pend[IRQ_MEI])      irq_code = IRQ_MEI;
    else if (pend[IRQ_MSI]) irq_code = IRQ_MSI;
    else if (pend[IRQ_MTI]) irq_code = IRQ_MTI;
  end

  assign irq_req     = mstatus_q[MSTATUS_MIE] && (|pend);
  assign irq_cause   = {1'b1, 26'b0, irq_code};
  assign trap_vector = {mtvec_q[XLEN-1:2], 2'b00}
                     + ((mtvec_q[0] && trap_cause[XLEN-1]) ? {26'b0, trap_cause[3:0], 2'b00} : '0);
  assign mepc_o      = mepc_q;
  assign mstatus_o   = mstatus_rd;

endmodule

// File: tb/tb_csr_trap_unit.sv
// tb/tb_csr_trap_unit.sv - directed and randomized checks of csr_trap_unit against a reference model
module tb_csr_trap_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] raddr, waddr;
  logic [31:0] rdata, wdata, trap_cause, trap_pc, trap_val;
  logic [31:0] irq_cause, trap_vector, mepc_o, mstatus_o;
  logic        rd_illegal, csr_w, retire, trap_valid, mret;
  logic        irq_ext, irq_timer, irq_sw, irq_req;
  logic [1:0]  csr_wsc_mode;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state, held as plain architectural values.
  logic        m_mie_b, m_mpie;
  logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mip;
  logic [63:0] m_cycle, m_instret;

  logic [11:0] addr_tab [14];

  csr_trap_unit dut (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata), .rd_illegal(rd_illegal),
    .waddr(waddr), .wdata(wdata), .csr_w(csr_w), .csr_wsc_mode(csr_wsc_mode),
    .retire(retire), .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .trap_val(trap_val), .mret(mret), .irq_ext(irq_ext), .irq_timer(irq_timer),
    .irq_sw(irq_sw), .irq_req(irq_req), .irq_cause(irq_cause), .trap_vector(trap_vector),
    .mepc_o(mepc_o), .mstatus_o(mstatus_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic mdl_illegal(input logic [11:0] a);
    return !(a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                       12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82});
  endfunction

  function automatic logic [31:0] mdl_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie_b ? 32'h8 : 32'h0);
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return m_mip;
      12'hB00: return m_cycle[31:0];
      12'hB80: return m_cycle[63:32];
      12'hB02: return m_instret[31:0];
      12'hB82: return m_instret[63:32];
      default: return 32'h0;
    endcase
  endfunction

  task automatic mdl_reset();
    m_mie_b = 0; m_mpie = 0; m_mie = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0;
    m_mcause = 0; m_mtval = 0; m_mip = 0; m_cycle = 0; m_instret = 0;
  endtask

  // Computes the next architectural state from the current inputs, then advances one clock.
  task automatic tick();
    logic [31:0] cur, nv, n_mie, n_mtvec, n_scr, n_mepc, n_mcause, n_mtval, n_mip;
    logic        n_mie_b, n_mpie, w;
    logic [63:0] n_cycle, n_instret;
    cur = mdl_read(waddr);
    nv = (csr_wsc_mode == 2'b10) ? (cur | wdata) :
         (csr_wsc_mode == 2'b11) ? (cur & ~wdata) : wdata;
    w = csr_w && !mdl_illegal(waddr);
    n_mie_b = m_mie_b; n_mpie = m_mpie; n_mie = m_mie; n_mtvec = m_mtvec; n_scr = m_mscratch;
    n_mepc = m_mepc; n_mcause = m_mcause; n_mtval = m_mtval;
    n_mip = (irq_ext ? 32'h800 : 0) | (irq_timer ? 32'h80 : 0) | (irq_sw ? 32'h8 : 0);
    n_cycle = m_cycle + 1;
    n_instret = retire ? m_instret + 1 : m_instret;
    if (w && waddr == 12'hB00) n_cycle = {m_cycle[63:32], nv};
    if (w && waddr == 12'hB80) n_cycle = {nv, m_cycle[31:0]};
    if (w && waddr == 12'hB02) n_instret = {m_instret[63:32], nv};
    if (w && waddr == 12'hB82) n_instret = {nv, m_instret[31:0]};
    if (w && waddr == 12'h304) n_mie = nv & 32'h888;
    if (w && waddr == 12'h305) n_mtvec = nv & ~32'h2;
    if (w && waddr == 12'h340) n_scr = nv;
    if (trap_valid) begin
      n_mpie = m_mie_b; n_mie_b = 0;
      n_mepc = trap_pc & ~32'h3; n_mcause = trap_cause; n_mtval = trap_val;
    end else begin
      if (mret) begin
        n_mie_b = m_mpie; n_mpie = 1;
      end else if (w && waddr == 12'h300) begin
        n_mie_b = nv[3]; n_mpie = nv[7];
      end
      if (w && waddr == 12'h341) n_mepc = nv & ~32'h3;
      if (w && waddr == 12'h342) n_mcause = nv;
      if (w && waddr == 12'h343) n_mtval = nv;
    end
    @(posedge clk);
    m_mie_b = n_mie_b; m_mpie = n_mpie; m_mie = n_mie; m_mtvec = n_mtvec; m_mscratch = n_scr;
    m_mepc = n_mepc; m_mcause = n_mcause; m_mtval = n_mtval; m_mip = n_mip;
    m_cycle = n_cycle; m_instret = n_instret;
    #1;
  endtask

  task automatic idle();
    csr_w = 0; csr_wsc_mode = 2'b00; waddr = 0; wdata = 0; retire = 0;
    trap_valid = 0; mret = 0; trap_cause = 0; trap_pc = 0; trap_val = 0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [1:0] mode, input logic [31:0] d);
    csr_w = 1; waddr = a; csr_wsc_mode = mode; wdata = d;
    tick();
    csr_w = 0;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    raddr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic model_chk(input string tag);
    logic [31:0] pend, exp_vec;
    pend = m_mip & m_mie;
    chk({tag, "_rdata"}, rdata, mdl_read(raddr));
    chk({tag, "_illegal"}, {31'b0, rd_illegal}, {31'b0, mdl_illegal(raddr)});
    chk({tag, "_irq_req"}, {31'b0, irq_req}, {31'b0, m_mie_b && (pend != 0)});
    if (pend != 0)
      chk({tag, "_irq_cause"}, irq_cause,
          pend[11] ? 32'h8000_000B : pend[3] ? 32'h8000_0003 : 32'h8000_0007);
    exp_vec = m_mtvec & ~32'h3;
    if (m_mtvec[0] && trap_cause[31]) exp_vec = exp_vec + 4 * trap_cause[3:0];
    chk({tag, "_vector"}, trap_vector, exp_vec);
    chk({tag, "_mepc"}, mepc_o, m_mepc);
    chk({tag, "_mstatus"}, mstatus_o, mdl_read(12'h300));
  endtask

  initial begin
    addr_tab = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'h7C0, 12'h301};
    rst_n = 0; raddr = 0; irq_ext = 0; irq_timer = 0; irq_sw = 0;
    idle();
    mdl_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    rd_chk("rst_mstatus", 12'h300, 32'h1800);
    rd_chk("rst_mie", 12'h304, 32'h0);
    rd_chk("rst_mtvec", 12'h305, 32'h0);
    rd_chk("illegal_rdata", 12'h7C0, 32'h0);
    chk("illegal_flag", {31'b0, rd_illegal}, 32'h1);
    chk("rst_irq_req", {31'b0, irq_req}, 32'h0);

    wr(12'h300, 2'b01, 32'hFFFF_FFFF); rd_chk("mstatus_warl", 12'h300, 32'h1888);
    wr(12'h300, 2'b11, 32'h8);         rd_chk("mstatus_clear", 12'h300, 32'h1880);
    wr(12'h304, 2'b01, 32'hFFFF_FFFF); rd_chk("mie_warl", 12'h304, 32'h888);
    wr(12'h305, 2'b01, 32'h1003);      rd_chk("mtvec_warl", 12'h305, 32'h1001);
    wr(12'h300, 2'b10, 32'h8);         rd_chk("mstatus_set", 12'h300, 32'h1888);

    irq_timer = 1;
    #1 chk("irq_lat0", {31'b0, irq_req}, 32'h0);
    tick();
    chk("irq_lat1", {31'b0, irq_req}, 32'h1);
    chk("irq_cause_mti", irq_cause, 32'h8000_0007);
    irq_ext = 1;
    tick();
    chk("irq_cause_mei", irq_cause, 32'h8000_000B);

    trap_valid = 1; trap_cause = 32'h8000_000B; trap_pc = 32'h202; trap_val = 32'h1234;
    #1 chk("trap_vector", trap_vector, 32'h102C);
    tick();
    idle();
    chk("trap_mepc", mepc_o, 32'h200);
    chk("trap_mstatus", mstatus_o, 32'h1880);
    rd_chk("trap_mcause", 12'h342, 32'h8000_000B);
    rd_chk("trap_mtval", 12'h343, 32'h1234);
    mret = 1;
    tick();
    mret = 0;
    chk("mret_mstatus", mstatus_o, 32'h1888);
    irq_ext = 0; irq_timer = 0;

    wr(12'hB00, 2'b01, 32'hFFFF_FFFF);
    rd_chk("mcycle_wr", 12'hB00, 32'hFFFF_FFFF);
    tick();
    rd_chk("mcycle_wrap", 12'hB00, 32'h0);
    rd_chk("mcycleh_carry", 12'hB80, 32'h1);
    retire = 1;
    wr(12'hB02, 2'b01, 32'h5);
    retire = 0;
    rd_chk("minstret_wr_wins", 12'hB02, 32'h5);

    trap_valid = 1; trap_cause = 32'h3; trap_pc = 32'h104; mret = 1;
    csr_w = 1; waddr = 12'h340; csr_wsc_mode = 2'b01; wdata = 32'hCAFE;
    tick();
    idle();
    chk("prio_mstatus", mstatus_o, 32'h1880);
    chk("prio_mepc", mepc_o, 32'h104);
    rd_chk("prio_mscratch", 12'h340, 32'hCAFE);
    rd_chk("prio_mcause", 12'h342, 32'h3);

    for (int i = 0; i < 400; i++) begin
      raddr        = addr_tab[$urandom_range(0, 13)];
      waddr        = addr_tab[$urandom_range(0, 13)];
      wdata        = $urandom;
      csr_w        = ($urandom_range(0, 2) == 0);
      csr_wsc_mode = 2'($urandom);
      retire       = 1'($urandom);
      trap_valid   = ($urandom_range(0, 7) == 0);
      mret         = ($urandom_range(0, 7) == 0);
      trap_cause   = $urandom;
      trap_pc      = $urandom;
      trap_val     = $urandom;
      irq_ext      = ($urandom_range(0, 3) == 0);
      irq_timer    = 1'($urandom);
      irq_sw       = 1'($urandom);
      #1 model_chk("rand");
      tick();
    end
    idle();
    irq_ext = 0; irq_timer = 0; irq_sw = 0;
    tick();

    wr(12'h340, 2'b01, 32'h5A5A);
    trap_valid = 1; mret = 1; trap_pc = 32'h400;
    rst_n = 0;
    #1 chk("async_mstatus", mstatus_o, 32'h1800);
    chk("async_mepc", mepc_o, 32'h0);
    rd_chk("async_mscratch", 12'h340, 32'h0);
    rd_chk("async_mcycle", 12'hB00, 32'h0);
    @(posedge clk);
    #1 chk("held_mstatus", mstatus_o, 32'h1800);
    idle();
    mdl_reset();
    rst_n = 1;
    tick();
    tick();
    #1 model_chk("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
